// File: rtl/alu_bus_unit_if.sv
// rtl/alu_bus_unit_if.sv - shared bus and strobe bundle for the bus-attached ALU
interface alu_bus_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_out;
    logic [2:0]       op_code;
    logic             a_latch;
    logic             b_latch;
    logic             out_latch;
    logic             out_en;
    logic             busy;
    logic [3:0]       flags;

    modport master (
        output bus_in, op_code, a_latch, b_latch, out_latch, out_en,
        input  bus_out, busy, flags
    );

    modport slave (
        input  bus_in, op_code, a_latch, b_latch, out_latch, out_en,
        output bus_out, busy, flags
    );
endinterface

// File: rtl/alu_bus_unit.sv
// rtl/alu_bus_unit.sv - bus-attached ALU with flags, shifts and shift-add multiplier
module alu_bus_unit #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    alu_bus_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state, state_next;
    logic [WIDTH-1:0]     a_q, b_q, r_q;
    logic [3:0]           flags_q;
    logic [2*WIDTH-1:0]   mc_q, acc_q, acc_next;
    logic [WIDTH-1:0]     mp_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH:0]       sum, diff;
    logic [WIDTH-1:0]     alu_r;
    logic                 alu_c, alu_v;
    logic                 mul_start, mul_done;

    // Single-cycle operations evaluated from the pre-edge A/B registers
    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        diff  = {1'b0, a_q} - {1'b0, b_q};
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (bus.op_code)
            3'b000: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b001: begin
                alu_r = diff[WIDTH-1:0];
                alu_c = ~diff[WIDTH];
                alu_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b010: alu_r = a_q & b_q;
            3'b011: alu_r = a_q | b_q;
            3'b100: alu_r = a_q ^ b_q;
            3'b101: alu_r = '0;
            3'b110: begin
                alu_r = {a_q[WIDTH-2:0], 1'b0};
                alu_c = a_q[WIDTH-1];
            end
            default: begin
                alu_r = {1'b0, a_q[WIDTH-1:1]};
                alu_c = a_q[0];
            end
        endcase
    end

    // Next-state logic: start a multiply from IDLE, finish after WIDTH iterations
    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        mul_done   = 1'b0;
        acc_next   = acc_q + (mp_q[0] ? mc_q : '0);
        case (state)
            IDLE: begin
                if (bus.out_latch && bus.op_code == OP_MUL && MUL_EN) begin
                    mul_start  = 1'b1;
                    state_next = MUL;
                end
            end
            default: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    mul_done   = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand, result, flag and multiplier datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            flags_q <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (state == IDLE) begin
            if (bus.a_latch) a_q <= bus.bus_in;
            if (bus.b_latch) b_q <= bus.bus_in;
            if (mul_start) begin
                mc_q  <= {{WIDTH{1'b0}}, a_q};
                mp_q  <= b_q;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (bus.out_latch) begin
                r_q     <= alu_r;
                flags_q <= {alu_r == '0, alu_r[WIDTH-1], alu_c, alu_v};
            end
        end else begin
            acc_q <= acc_next;
            mc_q  <= mc_q << 1;
            mp_q  <= mp_q >> 1;
            cnt_q <= cnt_q + 1'b1;
            if (mul_done) begin
                r_q     <= acc_next[WIDTH-1:0];
                flags_q <= {acc_next[WIDTH-1:0] == '0, acc_next[WIDTH-1],
                            |acc_next[2*WIDTH-1:WIDTH], 1'b0};
            end
        end
    end

    assign bus.busy    = (state == MUL);
    assign bus.flags   = flags_q;
    assign bus.bus_out = bus.out_en ? r_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_alu_bus_unit.sv
// tb/tb_alu_bus_unit.sv - scoreboard bench for alu_bus_unit
module tb_alu_bus_unit;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_bus_unit_if #(.WIDTH(W)) bus();

    alu_bus_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [19:0] exp_q[$];
    int ma = 0;
    int mb = 0;
    int last_r = 0;

    // Reference: {R[15:0], Z, N, C, V} from plain integer arithmetic
    function automatic logic [19:0] model(input int op, input int a, input int b);
        longint m, r, c, v, sa, sb, s, p;
        m = 65536;
        c = 0;
        v = 0;
        sa = (a >= 32768) ? a - m : a;
        sb = (b >= 32768) ? b - m : b;
        case (op)
            0: begin
                r = (a + b) % m;
                c = (a + b >= m) ? 1 : 0;
                s = sa + sb;
                v = (s > 32767 || s < -32768) ? 1 : 0;
            end
            1: begin
                r = (a - b + m) % m;
                c = (a >= b) ? 1 : 0;
                s = sa - sb;
                v = (s > 32767 || s < -32768) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin
                p = longint'(a) * longint'(b);
                r = p % m;
                c = (p >= m) ? 1 : 0;
            end
            6: begin
                r = (a * 2) % m;
                c = (a >= 32768) ? 1 : 0;
            end
            default: begin
                r = a / 2;
                c = a % 2;
            end
        endcase
        return {16'(r), (r == 0), (r >= 32768), c[0], v[0]};
    endfunction

    function automatic int pick();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 'h7FFF;
            2: return 'h8000;
            3: return 'hFFFF;
            default: return int'($urandom_range(0, 65535));
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input int v);
        bus.bus_in  = 16'(v);
        bus.a_latch = 1'b1;
        tick();
        bus.a_latch = 1'b0;
        ma = v;
    endtask

    task automatic load_b(input int v);
        bus.bus_in  = 16'(v);
        bus.b_latch = 1'b1;
        tick();
        bus.b_latch = 1'b0;
        mb = v;
    endtask

    // Issue one operation; optionally reload A on the same edge or disturb a running multiply
    task automatic run(input int op, input bit interfere, input bit with_a, input int av);
        logic [19:0] e;
        int n;
        int prev_r;
        prev_r = last_r;
        e = model(op, ma, mb);
        exp_q.push_back(e);
        last_r = int'(e[19:4]);
        bus.op_code   = 3'(op);
        bus.out_latch = 1'b1;
        if (with_a) begin
            bus.bus_in  = 16'(av);
            bus.a_latch = 1'b1;
        end
        tick();
        bus.out_latch = 1'b0;
        bus.a_latch   = 1'b0;
        if (with_a) ma = av;
        if (op == 5) begin
            n = 0;
            while (bus.busy && n < 100) begin
                if (n == 3) chk("bus_during_busy", bus.bus_out, prev_r);
                if (interfere && n == 0) begin
                    bus.bus_in    = 16'h00FF;
                    bus.a_latch   = 1'b1;
                    bus.b_latch   = 1'b1;
                    bus.out_latch = 1'b1;
                    bus.op_code   = 3'd0;
                end
                tick();
                n++;
                bus.a_latch   = 1'b0;
                bus.b_latch   = 1'b0;
                bus.out_latch = 1'b0;
            end
            chk("busy_cycles", n, 16);
        end
    endtask

    // Monitor: compare against the scoreboard whenever a capture has completed
    bit pend = 1'b0;
    bit rst_pend = 1'b1;
    bit prev_busy = 1'b0;
    initial begin
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (pend || (prev_busy && !bus.busy && !rst_pend)) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_result", bus.bus_out, e[19:4]);
                    chk("sb_flags", bus.flags, e[3:0]);
                end
            end
            pend      = bus.out_latch && !bus.busy && !rst && (bus.op_code != 3'd5);
            rst_pend  = rst;
            prev_busy = bus.busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int op;
        bus.bus_in    = '0;
        bus.op_code   = '0;
        bus.a_latch   = 1'b0;
        bus.b_latch   = 1'b0;
        bus.out_latch = 1'b0;
        bus.out_en    = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("reset_bus", bus.bus_out, 16'h0000);
        chk("reset_flags", bus.flags, 4'b0000);
        chk("reset_busy", bus.busy, 1'b0);

        load_a(2); load_b(1);
        run(0, 0, 0, 0);
        chk("add_2_1", bus.bus_out, 16'h0003);
        bus.out_en = 1'b0;
        #1;
        total++;
        if (bus.bus_out === 16'h0003) begin
            bad++;
            $display("FAIL out_en_low got=%h exp=z", bus.bus_out);
        end
        bus.out_en = 1'b1;
        run(1, 0, 0, 0);
        chk("sub_2_1_flags", bus.flags, 4'b0010);
        load_b(3);
        run(1, 0, 0, 0);
        chk("sub_2_3", bus.bus_out, 16'hFFFF);
        chk("sub_2_3_flags", bus.flags, 4'b0100);

        load_a('h7FFF); load_b(1);
        run(0, 0, 0, 0);
        chk("add_ovf_flags", bus.flags, 4'b0101);
        load_a('hFFFF);
        run(0, 0, 0, 0);
        chk("add_wrap_flags", bus.flags, 4'b1010);

        load_a('h8001);
        run(6, 0, 0, 0);
        chk("shl", bus.bus_out, 16'h0002);
        run(7, 0, 1, 1);
        chk("shr_pre_edge_a", bus.bus_out, 16'h4000);
        run(7, 0, 0, 0);
        chk("shr_1_flags", bus.flags, 4'b1010);

        load_a(3); load_b(5);
        run(5, 0, 0, 0);
        chk("mul_3_5", bus.bus_out, 16'h000F);
        run(5, 1, 0, 0);
        run(0, 0, 0, 0);
        chk("a_b_kept", bus.bus_out, 16'h0008);

        load_a(7); load_b(9);
        exp_q.push_back(model(5, ma, mb));
        bus.op_code   = 3'd5;
        bus.out_latch = 1'b1;
        tick();
        bus.out_latch = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(exp_q.pop_back());
        ma = 0; mb = 0; last_r = 0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_bus", bus.bus_out, 16'h0000);
        chk("abort_flags", bus.flags, 4'b0000);

        load_a('h0100); load_b('h0100);
        run(5, 0, 0, 0);
        chk("mul_big_flags", bus.flags, 4'b1010);

        for (int i = 0; i < 30; i++) begin
            int m;
            m  = int'($urandom_range(0, 3));
            op = int'($urandom_range(0, 7));
            if (m == 0 || m == 2) load_a(pick());
            if (m == 1 || m == 2) load_b(pick());
            run(op, 1'($urandom_range(0, 1)), (op != 5) && ($urandom_range(0, 3) == 0), pick());
        end

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
